kara_div128_seq: RTL and testbench

- Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient plus W-bit remainder.
- Inverse of the Karatsuba multiplier path. Takes a 128-bit product and recovers the cofactor, or reduces the product modulo a 64-bit modulus.
- Used for result checking and plain modular reduction beside the Montgomery datapath.
- Valid/ready on both sides; one quotient bit per clock.

---
 rtl/kara_div_pkg.sv | 14 +
 rtl/kara_div_step.sv | 24 ++
 rtl/kara_div128_seq.sv | 114 +++++++++++
 tb/tb_kara_div128_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kara_div_pkg.sv
// Shared constants and FSM state encoding for the sequential 2W/W restoring divider.
package kara_div_pkg;

    localparam int unsigned KD_W  = 64;
    localparam int unsigned KD_W2 = 2 * KD_W;
    localparam int unsigned KD_CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/kara_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module kara_div_step
    import kara_div_pkg::*;
#(
    parameter int unsigned W = KD_W
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    // With i_rem < i_div the true difference lies in (-2^W, 2^W), so bit W is the sign.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_div};
    assign o_qbit  = ~w_diff[W];
    assign o_rem   = o_qbit ? w_diff[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/kara_div128_seq.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, valid/ready handshake on operands and result.
module kara_div128_seq
    import kara_div_pkg::*;
#(
    parameter int unsigned W  = KD_W,
    parameter int unsigned CW = KD_CW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    state_t         r_state;
    state_t         w_next;
    logic [2*W-1:0] r_q;
    logic [W-1:0]   r_r;
    logic [W-1:0]   r_d;
    logic [CW-1:0]  r_cnt;
    logic           r_dbz;

    logic           w_accept;
    logic           w_last;
    logic           w_div_zero;
    logic [W-1:0]   w_step_rem;
    logic           w_step_qbit;

    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_last     = (r_cnt == CW'(2 * W - 1));
    assign w_div_zero = (divisor == '0);

    kara_div_step #(
        .W (W)
    ) u_step (
        .i_rem  (r_r),
        .i_bit  (r_q[2*W-1]),
        .i_div  (r_d),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Q and R double as the result registers; they only move on accept or in RUN,
    // so the last result stays visible after DONE exits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_d   <= divisor;
            r_cnt <= '0;
            if (w_div_zero) begin
                r_q   <= '1;
                r_r   <= dividend[W-1:0];
                r_dbz <= 1'b1;
            end else begin
                r_q   <= dividend;
                r_r   <= '0;
                r_dbz <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_r   <= w_step_rem;
            r_q   <= {r_q[2*W-2:0], w_step_qbit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_kara_div128_seq.sv
// Directed and randomized self-checking bench for kara_div128_seq and its step unit.
module tb_kara_div128_seq;
    import kara_div_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   dividend = '0;
    logic [63:0]    divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   quotient;
    logic [63:0]    remainder;
    logic           div_by_zero;

    logic [7:0]     s_rem = '0;
    logic           s_bit = 1'b0;
    logic [7:0]     s_div = '0;
    logic [7:0]     s_rem_o;
    logic           s_qbit;

    int unsigned    n_total = 0;
    int unsigned    n_pass  = 0;

    always #5 clk = ~clk;

    kara_div128_seq #(
        .W  (64),
        .CW (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    kara_div_step #(
        .W (8)
    ) u_step (
        .i_rem  (s_rem),
        .i_bit  (s_bit),
        .i_div  (s_div),
        .o_rem  (s_rem_o),
        .o_qbit (s_qbit)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [127:0] a, input logic [63:0] b);
        int unsigned g = 0;
        while (!in_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready before accept", 192'(in_ready), 192'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Number of clock edges after the accepting edge until out_valid is seen.
    task automatic wait_result(output int unsigned lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [127:0] a, input logic [63:0] b,
                          output logic [127:0] q, output logic [63:0] r,
                          output logic z, output int unsigned lat);
        start_op(a, b);
        wait_result(lat);
        q = quotient;
        r = remainder;
        z = div_by_zero;
        consume();
    endtask

    initial begin
        logic [127:0] q, a128, exp_q;
        logic [63:0]  r, a64, b64;
        logic         z;
        int unsigned  lat;
        int unsigned  seen;
        logic         stable;
        logic [127:0] q0;
        logic [63:0]  r0;

        // Step unit: hand-computed 8-bit cases.
        s_rem = 8'h03; s_bit = 1'b1; s_div = 8'h05; #1;
        chk("step 7-5 rem", 192'(s_rem_o), 192'(8'h02));
        chk("step 7-5 qbit", 192'(s_qbit), 192'(1));
        s_rem = 8'h02; s_bit = 1'b0; s_div = 8'h05; #1;
        chk("step 4<5 rem", 192'(s_rem_o), 192'(8'h04));
        chk("step 4<5 qbit", 192'(s_qbit), 192'(0));
        s_rem = 8'h80; s_bit = 1'b1; s_div = 8'hFF; #1;
        chk("step 257-255 rem", 192'(s_rem_o), 192'(8'h02));
        chk("step 257-255 qbit", 192'(s_qbit), 192'(1));

        // Reset state.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset out_valid", 192'(out_valid), 192'(0));
        chk("reset in_ready", 192'(in_ready), 192'(1));
        chk("reset quotient", 192'(quotient), 192'(0));
        chk("reset remainder", 192'(remainder), 192'(0));
        chk("reset div_by_zero", 192'(div_by_zero), 192'(0));

        // Reset mid-RUN aborts the operation.
        start_op(128'd1000, 64'd7);
        chk("in_ready during RUN", 192'(in_ready), 192'(0));
        seen = 0;
        repeat (48) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid-run reset in_ready", 192'(in_ready), 192'(1));
        chk("mid-run reset quotient", 192'(quotient), 192'(0));
        repeat (200) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("aborted op never valid", 192'(seen), 192'(0));
        run_op(128'd1000, 64'd7, q, r, z, lat);
        chk("1000/7 quotient", 192'(q), 192'(142));
        chk("1000/7 remainder", 192'(r), 192'(6));
        chk("1000/7 latency", 192'(lat), 192'(128));

        // Basic.
        run_op(128'd100, 64'd7, q, r, z, lat);
        chk("100/7 quotient", 192'(q), 192'(14));
        chk("100/7 remainder", 192'(r), 192'(2));
        chk("100/7 div_by_zero", 192'(z), 192'(0));
        chk("100/7 latency", 192'(lat), 192'(128));
        chk("after consume out_valid", 192'(out_valid), 192'(0));
        chk("after consume in_ready", 192'(in_ready), 192'(1));

        // Max values.
        run_op('1, 64'hFFFF_FFFF_FFFF_FFFF, q, r, z, lat);
        chk("max/max quotient", 192'(q), 192'(128'h1_0000_0000_0000_0001));
        chk("max/max remainder", 192'(r), 192'(0));
        run_op('1, 64'd1, q, r, z, lat);
        chk("max/1 quotient", 192'(q), {64'd0, {128{1'b1}}});
        chk("max/1 remainder", 192'(r), 192'(0));

        // Divide by zero.
        run_op(128'h1234_5678_9ABC_DEF0, 64'd0, q, r, z, lat);
        chk("div0 quotient", 192'(q), {64'd0, {128{1'b1}}});
        chk("div0 remainder", 192'(r), 192'(64'h1234_5678_9ABC_DEF0));
        chk("div0 flag", 192'(z), 192'(1));
        chk("div0 latency", 192'(lat), 192'(0));

        // Edge cases.
        run_op(128'd0, 64'd5, q, r, z, lat);
        chk("zero dividend quotient", 192'(q), 192'(0));
        chk("zero dividend remainder", 192'(r), 192'(0));
        chk("zero dividend flag clears", 192'(z), 192'(0));
        run_op(128'd5, 64'h10, q, r, z, lat);
        chk("small dividend quotient", 192'(q), 192'(0));
        chk("small dividend remainder", 192'(r), 192'(5));

        // Backpressure: 2^64 / 3 = 0x5555555555555555 rem 1.
        start_op(128'h1_0000_0000_0000_0000, 64'd3);
        wait_result(lat);
        q0 = quotient;
        r0 = remainder;
        chk("bp quotient", 192'(q0), 192'(64'h5555_5555_5555_5555));
        chk("bp remainder", 192'(r0), 192'(1));
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            dividend = {$urandom, $urandom, $urandom, $urandom};
            divisor  = 64'd5;
            @(negedge clk);
            if (quotient !== q0 || remainder !== r0 || out_valid !== 1'b1 ||
                in_ready !== 1'b0 || div_by_zero !== 1'b0) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp outputs stable", 192'(stable), 192'(1));
        consume();
        chk("bp single transfer", 192'(out_valid), 192'(0));
        chk("bp back to idle", 192'(in_ready), 192'(1));
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        chk("bp no queued accept", 192'(seen), 192'(0));
        chk("bp result held", 192'(quotient), 192'(q0));

        // Multiplier round-trip.
        for (int i = 0; i < 100; i++) begin
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            if (b64 == '0) b64 = 64'd1;
            a128 = 128'(a64) * 128'(b64);
            run_op(a128, b64, q, r, z, lat);
            chk("roundtrip quotient", 192'(q), 192'(a64));
            chk("roundtrip remainder", 192'(r), 192'(0));
        end

        // Random pairs against the division invariant.
        for (int i = 0; i < 150; i++) begin
            a128 = {$urandom, $urandom, $urandom, $urandom};
            case (i % 3)
                0:       b64 = {$urandom, $urandom};
                1:       b64 = 64'($urandom);
                default: b64 = 64'($urandom_range(255, 1));
            endcase
            if (b64 == '0) b64 = 64'd1;
            exp_q = a128 / 128'(b64);
            run_op(a128, b64, q, r, z, lat);
            chk("invariant q*d+r", 192'(q) * 192'(b64) + 192'(r), 192'(a128));
            chk("invariant r<d", 192'(r < b64), 192'(1));
            chk("random quotient", 192'(q), 192'(exp_q));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
